// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter.
package rr_arb_pkg;

    localparam int unsigned NUM_REQ = 8;
    localparam int unsigned IDX_W   = 3;

    localparam logic [NUM_REQ-1:0] GNT_NONE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // First set request bit at or above ptr, wrapping 7 -> 0.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] idx;
        logic [IDX_W-1:0] cand;
        logic             found;
        idx   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = ptr + IDX_W'(k);
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/gnt_dec3to8_n.sv
// 3-to-8 active-low grant decoder; all outputs high when not valid.
module gnt_dec3to8_n
    import rr_arb_pkg::*;
(
    input  logic [IDX_W-1:0]   idx,
    input  logic               valid,
    output logic [NUM_REQ-1:0] gnt_n_c
);

    // Drive exactly one low bit, and only for a held grant.
    always_comb begin
        gnt_n_c = GNT_NONE;
        if (valid) begin
            gnt_n_c[idx] = 1'b0;
        end
    end

endmodule

// File: rtl/rr_arb8_dec.sv
// 8-requester round-robin arbiter with registered active-low one-hot grant.
// Optional grant timeout is compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_arb8_dec
    import rr_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               done,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic [NUM_REQ-1:0] gnt_n,
    output logic               gnt_valid
`ifdef RR_ARB_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [IDX_W-1:0]   gnt_idx_d;
    logic               gnt_valid_d;
    logic [NUM_REQ-1:0] gnt_n_c;

`ifdef RR_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_d;
`else
    // Without the timeout the parameter only keeps the interface uniform.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    // Decode the next grant so gnt_n registers alongside gnt_idx/gnt_valid.
    gnt_dec3to8_n u_dec (
        .idx     (gnt_idx_d),
        .valid   (gnt_valid_d),
        .gnt_n_c (gnt_n_c)
    );

    // Next-state, pointer and grant output logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_idx_d   = gnt_idx;
        gnt_valid_d = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        cnt_d       = '0;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_idx_d   = rr_pick(req, ptr_q);
                    gnt_valid_d = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                gnt_valid_d = 1'b1;
                if (done || !req[gnt_idx]) begin
                    // Owner release wins over a coincident expiry.
                    state_d     = RELEASE;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx + IDX_W'(1);
                end
`ifdef RR_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    state_d     = RELEASE;
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx + IDX_W'(1);
                    timeout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx   <= '0;
            gnt_n     <= GNT_NONE;
            gnt_valid <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx   <= gnt_idx_d;
            gnt_n     <= gnt_n_c;
            gnt_valid <= gnt_valid_d;
`ifdef RR_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout   <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_rr_arb8_dec.sv
// Self-checking bench for rr_arb8_dec: directed scenarios then random traffic
// against a behavioural model of the arbitration rules.
module tb_rr_arb8_dec;

    localparam int TO = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic       done;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_n;
    logic       gnt_valid;
`ifdef RR_ARB_TIMEOUT_EN
    logic       timeout;
`endif

    int total = 0;
    int bad   = 0;

    // Model state: owner busy, dead cycle in progress, pulse, owner, pointer.
    bit m_busy, m_dead, m_to;
    int m_idx, m_ptr, m_held;

    rr_arb8_dec #(.TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_n     (gnt_n),
        .gnt_valid (gnt_valid)
`ifdef RR_ARB_TIMEOUT_EN
        ,
        .timeout   (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the arbitration rules for one clock edge.
    task automatic model_edge(input logic [7:0] r, input logic d, input logic rn);
        m_to = 0;
        if (!rn) begin
            m_busy = 0; m_dead = 0; m_idx = 0; m_ptr = 0; m_held = 0;
        end else if (m_dead) begin
            m_dead = 0;
        end else if (m_busy) begin
            m_held++;
            if (d || !r[m_idx]) begin
                m_busy = 0; m_dead = 1; m_ptr = (m_idx + 1) % 8;
            end
`ifdef RR_ARB_TIMEOUT_EN
            else if (m_held == TO) begin
                m_busy = 0; m_dead = 1; m_ptr = (m_idx + 1) % 8; m_to = 1;
            end
`endif
        end else if (r != 8'h00) begin
            for (int k = 0; k < 8; k++) begin
                if (!m_busy && r[(m_ptr + k) % 8]) begin
                    m_idx  = (m_ptr + k) % 8;
                    m_busy = 1;
                    m_held = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [7:0] exp_n;
        exp_n = 8'hFF;
        if (m_busy) exp_n[m_idx[2:0]] = 1'b0;
        chk("gnt_valid", 32'(gnt_valid), 32'(m_busy));
        chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
        chk("gnt_n", 32'(gnt_n), 32'(exp_n));
        chk("ptr", 32'(dut.ptr_q), 32'(m_ptr));
        chk("onehot", 32'($countones(~gnt_n) <= 1), 32'd1);
`ifdef RR_ARB_TIMEOUT_EN
        chk("timeout", 32'(timeout), 32'(m_to));
`endif
    endtask

    // One clock: drive, take the edge, update the model, check #1 later.
    task automatic cyc(input logic [7:0] r, input logic d, input logic rn);
        req   = r;
        done  = d;
        rst_n = rn;
        @(posedge clk);
        model_edge(r, d, rn);
        #1;
        check_model();
    endtask

    initial begin
        int n;
        int exp_seq[4];
        logic [7:0] r;
        logic d;
        exp_seq = '{0, 7, 0, 7};
        req = 8'h00; done = 1'b0; rst_n = 1'b0;

        // Reset with all requests asserted.
        cyc(8'hFF, 1'b0, 1'b0);
        cyc(8'hFF, 1'b0, 1'b0);
        chk("rst_gnt_n", 32'(gnt_n), 32'hFF);
        chk("rst_valid", 32'(gnt_valid), 32'd0);
        chk("rst_ptr", 32'(dut.ptr_q), 32'd0);

        // Single requester 3, then release with a dead cycle.
        cyc(8'h08, 1'b0, 1'b1);
        chk("single_idx", 32'(gnt_idx), 32'd3);
        chk("single_gnt_n", 32'(gnt_n), 32'hF7);
        cyc(8'h08, 1'b1, 1'b1);
        chk("dead_gnt_n", 32'(gnt_n), 32'hFF);
        chk("dead_idx_hold", 32'(gnt_idx), 32'd3);
        cyc(8'h00, 1'b0, 1'b1);

        // Requesters 0 and 7 alternate, pointer wraps 7 -> 0.
        cyc(8'h81, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(8'h81, 1'b1, 1'b1);
            if (gnt_valid && n < 4) begin
                chk("rr_wrap_seq", 32'(gnt_idx), 32'(exp_seq[n]));
                n++;
            end
        end
        chk("rr_wrap_count", 32'(n), 32'd4);

        // Owner 5 drops its request; next grant goes to 7.
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h20, 1'b0, 1'b1);
        cyc(8'hA4, 1'b0, 1'b1);
        chk("drop_hold_idx", 32'(gnt_idx), 32'd5);
        cyc(8'h84, 1'b0, 1'b1);
        chk("drop_release", 32'(gnt_valid), 32'd0);
        cyc(8'h84, 1'b0, 1'b1);
        cyc(8'h84, 1'b0, 1'b1);
        chk("drop_next_idx", 32'(gnt_idx), 32'd7);
        cyc(8'h00, 1'b1, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);

        // Reset while requester 6 owns; first grant after follows ptr=0.
        cyc(8'h40, 1'b0, 1'b1);
        chk("rst_grant_idx", 32'(gnt_idx), 32'd6);
        cyc(8'h41, 1'b0, 1'b0);
        chk("rst_grant_drop", 32'(gnt_n), 32'hFF);
        cyc(8'h41, 1'b0, 1'b1);
        chk("rst_first_grant", 32'(gnt_idx), 32'd0);

        // Requester 1 holds without done.
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h02, 1'b0, 1'b1);
        for (int i = 0; i < TO - 1; i++) begin
            cyc(8'h02, 1'b0, 1'b1);
            chk("hold_valid", 32'(gnt_valid), 32'd1);
        end
        cyc(8'h02, 1'b0, 1'b1);
`ifdef RR_ARB_TIMEOUT_EN
        chk("to_pulse", 32'(timeout), 32'd1);
        chk("to_gnt_n", 32'(gnt_n), 32'hFF);
        cyc(8'h02, 1'b0, 1'b1);
        chk("to_pulse_end", 32'(timeout), 32'd0);
`else
        chk("no_to_hold", 32'(gnt_n), 32'hFD);
`endif

        // All eight request continuously: ascending order, each once per 8.
        cyc(8'h00, 1'b0, 1'b0);
        n = 0;
        for (int i = 0; i < 24; i++) begin
            cyc(8'hFF, 1'b1, 1'b1);
            if (gnt_valid) begin
                chk("full_rr_order", 32'(gnt_idx), 32'(n % 8));
                n++;
            end
        end
        chk("full_rr_count", 32'(n), 32'd8);

        // Random traffic against the model.
        r = 8'h00;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) r = 8'($urandom_range(0, 255));
            d = ($urandom_range(0, 5) == 0);
            cyc(r, d, ($urandom_range(0, 99) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
